huffman_decoder: RTL and testbench
==================================

Name: huffman_decoder

Overview:
- Bit-serial Huffman decoder; the receive-side counterpart of the HuffmanCode tree builder/encoder.
- Holds a 9-entry internal-node child table for a 10-symbol alphabet. Leaves are nodes 0..9, internal nodes are 10..18, root is 18.
- Walks the tree one code bit per cycle and emits each decoded 4-bit symbol over a valid/ready handshake.
- Sits between the bitstream source and the symbol consumer. The table is loaded by the controller before decoding starts.

Parameters:
- NSYM, 10, number of leaf symbols (node indices 0..NSYM-1).
- NODE_W, 5, width of a node index.
- ROOT, 18, root node index (2*NSYM-2).
- MAX_DEPTH, 9, maximum code length in bits (NSYM-1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- tbl_we  in  1  table write strobe.
- tbl_addr  in  4  table entry 0..8, maps to node tbl_addr+10.
- tbl_data  in  10  {child1[4:0], child0[4:0]}.
- start  in  1  pulse: enter RUN, cursor=ROOT, clear sym_count and err.
- stop  in  1  pulse: return to IDLE.
- bit_valid  in  1  code bit offered.
- bit_in  in  1  code bit value.
- bit_ready  out  1  decoder accepts bit this cycle.
- sym_valid  out  1  decoded symbol available.
- sym_data  out  4  decoded symbol index 0..9.
- sym_ready  in  1  consumer accepts symbol.
- busy  out  1  state is RUN.
- mid_symbol  out  1  cursor != ROOT (partial code consumed).
- err  out  1  sticky decode error.
- sym_count  out  16  symbols emitted since start.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, cursor=ROOT, depth=0.
  - All table entries = 0.
  - All outputs 0: sym_valid, sym_data, err, sym_count, busy, mid_symbol, bit_ready.
- States: IDLE, RUN, ERR (2-bit register).
- IDLE:
  - tbl_we writes table[tbl_addr] <= tbl_data; tbl_addr>8 is ignored.
  - bit_ready=0.
  - start -> RUN.
- RUN:
  - tbl_we is ignored.
  - bit_ready = !sym_valid || sym_ready (combinational; accept while the output slot drains).
  - Bit accept = bit_valid && bit_ready. On accept: nxt = bit_in ? table[cursor-10].child1 : table[cursor-10].child0.
    - nxt < NSYM: next cycle sym_valid=1, sym_data=nxt[3:0], sym_count+1 (wraps 0xFFFF->0), cursor=ROOT, depth=0.
    - NSYM <= nxt <= ROOT: cursor=nxt, depth+1.
    - nxt > ROOT: -> ERR.
    - depth == MAX_DEPTH-1 and nxt not a leaf: -> ERR.
  - Latency: a leaf-completing bit accepted in cycle n gives sym_valid in cycle n+1. Throughput is 1 bit per cycle.
  - Output slot: sym_valid clears on sym_valid && sym_ready unless a new leaf is reached in the same cycle, in which case it stays 1 with the new symbol.
  - stop -> IDLE; cursor=ROOT, depth=0, and a pending symbol is kept until taken.
- ERR:
  - err=1, bit_ready=0, cursor frozen.
  - A pending symbol is still delivered.
  - Exit only via start (-> RUN, err cleared) or rst.
- start has priority over stop. start while in RUN restarts: cursor=ROOT, count=0; a pending symbol is kept.
- busy=1 only in RUN. mid_symbol reflects the cursor register.
- rst asserted mid-symbol or mid-load: immediate clear of everything, including the table.

Test Plan:
- Skewed-tree decode.
  - Load node10={1,0}, node11={10,2}, node12={11,3}, ..., node18={17,9}; start.
  - Stream bits 0,1,0,1,1,0 with sym_ready=1 -> symbols 9,8,7, each 1 cycle after its last bit; sym_count=3.
  - Stream 9 ones -> symbol 1; 8 ones then 0 -> symbol 0. mid_symbol=1 between bits, 0 after each symbol.
- Backpressure.
  - Same tree, sym_ready=0, bits 0,0 -> sym_data=9 held, bit_ready=0 after the first bit, second bit stalled.
  - Raise sym_ready -> second bit accepted that cycle; second symbol 9 next cycle; no symbol lost or duplicated.
- Invalid child.
  - Load node18 child0=25, bit 0 -> err=1, state ERR, bit_ready=0, sym_count unchanged.
  - start -> err=0, RUN.
- Depth overflow.
  - Load node18={18,18} (self loop), feed 9 ones -> err=1 on the 9th bit; no symbol emitted.
- Control and reset.
  - tbl_we during RUN -> table unchanged; tbl_addr=12 in IDLE -> ignored.
  - stop after 3 bits of a symbol, then start -> decoding resumes from ROOT.
  - rst mid-symbol -> all outputs 0; table reads 0, so bit 0 then decodes to symbol 0 after a fresh start.

Source files
------------

// File: rtl/huffman_decoder.sv
// Bit-serial Huffman decoder: walks a loaded 9-entry internal-node child table
// one code bit per cycle and emits decoded symbols over a valid/ready handshake.
module huffman_decoder #(
  parameter int NSYM      = 10,
  parameter int NODE_W    = 5,
  parameter int ROOT      = 18,
  parameter int MAX_DEPTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tbl_we,
  input  logic [3:0]            tbl_addr,
  input  logic [2*NODE_W-1:0]   tbl_data,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  bit_valid,
  input  logic                  bit_in,
  output logic                  bit_ready,
  output logic                  sym_valid,
  output logic [3:0]            sym_data,
  input  logic                  sym_ready,
  output logic                  busy,
  output logic                  mid_symbol,
  output logic                  err,
  output logic [15:0]           sym_count
);

  localparam int DEPTH_W = $clog2(MAX_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, ERR = 2'd2} state_t;

  state_t               state;
  logic [NODE_W-1:0]    cursor;
  logic [DEPTH_W-1:0]   depth;
  logic [2*NODE_W-1:0]  tbl [0:NSYM-2];

  logic [3:0]           idx;
  logic [2*NODE_W-1:0]  entry;
  logic [NODE_W-1:0]    nxt;
  logic                 accept;
  logic                 is_leaf;
  logic                 is_bad;
  logic                 too_deep;

  // Cursor is always an internal node while running, so idx stays within 0..8.
  assign idx      = 4'(cursor - NODE_W'(NSYM));
  assign entry    = (idx < 4'(NSYM-1)) ? tbl[idx] : '0;
  assign nxt      = bit_in ? entry[2*NODE_W-1:NODE_W] : entry[NODE_W-1:0];
  assign is_leaf  = nxt < NODE_W'(NSYM);
  assign is_bad   = nxt > NODE_W'(ROOT);
  assign too_deep = depth == DEPTH_W'(MAX_DEPTH-1);

  assign bit_ready  = (state == RUN) && (!sym_valid || sym_ready);
  assign accept     = bit_valid && bit_ready;
  assign busy       = (state == RUN);
  assign mid_symbol = (cursor != NODE_W'(ROOT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cursor    <= NODE_W'(ROOT);
      depth     <= '0;
      sym_valid <= 1'b0;
      sym_data  <= '0;
      err       <= 1'b0;
      sym_count <= '0;
      for (int i = 0; i < NSYM-1; i++) tbl[i] <= '0;
    end else begin
      // Output slot drains independently of state; a new leaf below re-fills it.
      if (sym_valid && sym_ready) sym_valid <= 1'b0;

      if (start) begin
        state     <= RUN;
        cursor    <= NODE_W'(ROOT);
        depth     <= '0;
        err       <= 1'b0;
        sym_count <= '0;
      end else if (stop && state == RUN) begin
        state  <= IDLE;
        cursor <= NODE_W'(ROOT);
        depth  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (tbl_we && tbl_addr <= 4'(NSYM-2)) tbl[tbl_addr] <= tbl_data;
          end
          RUN: begin
            if (accept) begin
              if (is_bad || (too_deep && !is_leaf)) begin
                state <= ERR;
                err   <= 1'b1;
              end else if (is_leaf) begin
                sym_valid <= 1'b1;
                sym_data  <= nxt[3:0];
                sym_count <= sym_count + 16'd1;
                cursor    <= NODE_W'(ROOT);
                depth     <= '0;
              end else begin
                cursor <= nxt;
                depth  <= depth + DEPTH_W'(1);
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_huffman_decoder.sv
// Bench for huffman_decoder: a path-based reference decoder checked every cycle,
// plus hand-computed expectations for the directed scenarios.
module tb_huffman_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tbl_we = 1'b0;
  logic [3:0]  tbl_addr = '0;
  logic [9:0]  tbl_data = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        bit_valid = 1'b0;
  logic        bit_in = 1'b0;
  logic        sym_ready = 1'b0;
  logic        bit_ready;
  logic        sym_valid;
  logic [3:0]  sym_data;
  logic        busy;
  logic        mid_symbol;
  logic        err;
  logic [15:0] sym_count;

  huffman_decoder dut (
    .clk(clk), .rst(rst), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .start(start), .stop(stop), .bit_valid(bit_valid), .bit_in(bit_in),
    .bit_ready(bit_ready), .sym_valid(sym_valid), .sym_data(sym_data),
    .sym_ready(sym_ready), .busy(busy), .mid_symbol(mid_symbol), .err(err),
    .sym_count(sym_count)
  );

  always #5 clk = ~clk;

  localparam int S_IDLE = 0, S_RUN = 1, S_ERR = 2;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: the decoder position is the list of bits taken since the root.
  int m_state;
  int m_c0 [9];
  int m_c1 [9];
  bit m_path [$];
  bit m_valid;
  int m_data;
  bit m_err;
  int m_count;
  int got [$];

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int walk();
    int node = 18;
    foreach (m_path[i]) node = m_path[i] ? m_c1[node-10] : m_c0[node-10];
    return node;
  endfunction

  function automatic bit m_ready();
    return (m_state == S_RUN) && (!m_valid || sym_ready);
  endfunction

  task automatic model_reset();
    m_state = S_IDLE;
    for (int i = 0; i < 9; i++) begin m_c0[i] = 0; m_c1[i] = 0; end
    m_path.delete();
    m_valid = 0;
    m_data  = 0;
    m_err   = 0;
    m_count = 0;
  endtask

  task automatic model_step();
    bit acc;
    int n;
    if (rst) begin model_reset(); return; end
    acc = bit_valid && m_ready();
    if (m_valid && sym_ready) m_valid = 0;
    if (start) begin
      m_state = S_RUN; m_path.delete(); m_err = 0; m_count = 0;
    end else if (stop && m_state == S_RUN) begin
      m_state = S_IDLE; m_path.delete();
    end else if (m_state == S_IDLE) begin
      if (tbl_we && tbl_addr < 9) begin
        m_c1[int'(tbl_addr)] = int'(tbl_data[9:5]);
        m_c0[int'(tbl_addr)] = int'(tbl_data[4:0]);
      end
    end else if (m_state == S_RUN && acc) begin
      n = walk();
      n = bit_in ? m_c1[n-10] : m_c0[n-10];
      if (n > 18 || (n >= 10 && m_path.size() >= 8)) begin
        m_state = S_ERR; m_err = 1;
      end else if (n < 10) begin
        m_valid = 1; m_data = n; m_count = (m_count + 1) % 65536; m_path.delete();
      end else begin
        m_path.push_back(bit_in);
      end
    end
  endtask

  task automatic check();
    chk("sym_valid",  int'(sym_valid),  int'(m_valid));
    chk("sym_data",   int'(sym_data),   m_data);
    chk("err",        int'(err),        int'(m_err));
    chk("sym_count",  int'(sym_count),  m_count);
    chk("busy",       int'(busy),       int'(m_state == S_RUN));
    chk("mid_symbol", int'(mid_symbol), int'(walk() != 18));
    chk("bit_ready",  int'(bit_ready),  int'(m_ready()));
    if (sym_valid && sym_ready) got.push_back(int'(sym_data));
  endtask

  task automatic cycle();
    @(negedge clk);
    check();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(bit b);
    bit acc = 1'b0;
    bit_valid = 1'b1;
    bit_in = b;
    for (int k = 0; k < 20 && !acc; k++) begin
      acc = m_ready();
      cycle();
    end
    bit_valid = 1'b0;
    if (!acc) begin
      n_chk++;
      $display("FAIL send_bit: bit %0d not accepted within 20 cycles, expected acceptance", b);
    end
  endtask

  task automatic load(int a, int c1, int c0);
    tbl_we = 1'b1;
    tbl_addr = 4'(a);
    tbl_data = {5'(c1), 5'(c0)};
    cycle();
    tbl_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1; cycle(); stop = 1'b0;
  endtask

  initial begin
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("rst_sym_valid", int'(sym_valid), 0);
    chk("rst_sym_count", int'(sym_count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_mid", int'(mid_symbol), 0);
    chk("rst_bit_ready", int'(bit_ready), 0);
    cycle();
    rst = 1'b0;
    cycle();

    // Skewed tree: node10={1,0}, node n={n-1, n-9} for n=11..18.
    load(0, 1, 0);
    for (int n = 11; n <= 18; n++) load(n - 10, n - 1, n - 9);
    do_start();
    sym_ready = 1'b1;
    send_bit(0);
    chk("lat_valid", int'(sym_valid), 1);
    chk("lat_data", int'(sym_data), 9);
    send_bit(1);
    chk("mid_between", int'(mid_symbol), 1);
    send_bit(0);
    chk("sym8", int'(sym_data), 8);
    send_bit(1); send_bit(1); send_bit(0);
    cycle();
    chk("count3", int'(sym_count), 3);
    chk("seq_9", got.size() > 0 ? got[0] : -1, 9);
    chk("seq_7", got.size() > 2 ? got[2] : -1, 7);

    for (int i = 0; i < 9; i++) send_bit(1);
    chk("sym1", int'(sym_data), 1);
    chk("mid_after", int'(mid_symbol), 0);
    for (int i = 0; i < 8; i++) send_bit(1);
    send_bit(0);
    chk("sym0", int'(sym_data), 0);
    chk("count5", int'(sym_count), 5);
    cycle();

    // Backpressure
    sym_ready = 1'b0;
    send_bit(0);
    bit_valid = 1'b1; bit_in = 1'b0;
    #1;
    chk("bp_ready0", int'(bit_ready), 0);
    cycle(); cycle();
    chk("bp_hold_valid", int'(sym_valid), 1);
    chk("bp_hold_data", int'(sym_data), 9);
    chk("bp_hold_count", int'(sym_count), 6);
    sym_ready = 1'b1;
    #1;
    chk("bp_ready1", int'(bit_ready), 1);
    cycle();
    bit_valid = 1'b0;
    chk("bp_second_valid", int'(sym_valid), 1);
    chk("bp_count7", int'(sym_count), 7);
    cycle();
    chk("bp_nsyms", got.size(), 7);
    chk("bp_last", got.size() > 6 ? got[6] : -1, 9);

    // Invalid child
    do_stop();
    load(8, 17, 25);
    do_start();
    send_bit(1); send_bit(0);
    cycle();
    send_bit(0);
    chk("inv_err", int'(err), 1);
    chk("inv_busy", int'(busy), 0);
    chk("inv_ready", int'(bit_ready), 0);
    chk("inv_count", int'(sym_count), 1);
    cycle();
    do_stop();
    chk("inv_stop_ignored", int'(err), 1);
    do_start();
    chk("inv_clear", int'(err), 0);
    chk("inv_run", int'(busy), 1);

    // Depth overflow via self loop at root
    do_stop();
    load(8, 18, 18);
    do_start();
    for (int i = 0; i < 8; i++) send_bit(1);
    chk("deep_ok8", int'(err), 0);
    send_bit(1);
    chk("deep_err9", int'(err), 1);
    chk("deep_nosym", got.size(), 8);

    // Control: table writes outside IDLE or past the last entry are ignored
    do_start();
    do_stop();
    load(8, 17, 9);
    load(12, 1, 1);
    do_start();
    tbl_we = 1'b1; tbl_addr = 4'd8; tbl_data = {5'd18, 5'd18};
    cycle();
    tbl_we = 1'b0;
    send_bit(0);
    chk("we_run_ignored", int'(sym_data), 9);
    cycle();

    // Stop mid-symbol, then resume from root
    send_bit(1); send_bit(1); send_bit(1);
    chk("stop_mid_before", int'(mid_symbol), 1);
    do_stop();
    chk("stop_mid_after", int'(mid_symbol), 0);
    chk("stop_idle", int'(busy), 0);
    do_start();
    send_bit(0);
    chk("resume_root", int'(sym_data), 9);
    cycle();

    // Async reset mid-symbol clears the table too
    send_bit(1); send_bit(1);
    chk("rst_mid_before", int'(mid_symbol), 1);
    rst = 1'b1;
    #1;
    chk("rst2_mid", int'(mid_symbol), 0);
    chk("rst2_busy", int'(busy), 0);
    chk("rst2_count", int'(sym_count), 0);
    chk("rst2_data", int'(sym_data), 0);
    model_reset();
    cycle();
    rst = 1'b0;
    cycle();
    do_start();
    send_bit(0);
    chk("zero_tbl_valid", int'(sym_valid), 1);
    chk("zero_tbl_data", int'(sym_data), 0);
    chk("zero_tbl_count", int'(sym_count), 1);
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
